// File: rtl/sys_row_driver_pkg.sv
// Shared definitions for the systolic row driver.
//   state_t     : sequencer states (3-bit encoding)
//   data_width  : activation / weight byte width
//   sum_width   : partial-sum lane width
package sys_row_driver_pkg;

    localparam int data_width = 8;
    localparam int sum_width  = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        FIN    = 3'd4
    } state_t;

endpackage

// File: rtl/sys_row_flush_ctr.sv
// Loadable down-counter with a zero flag; times the pipeline flush.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val (has priority over dec)
//   load_val   : value to load
//   dec        : decrement by one, saturating at zero
//   zero       : count is zero
module sys_row_flush_ctr #(
    parameter int width = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [width-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [width-1:0] count;

    assign zero = (count == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && !zero) begin
            count <= count - width'(1);
        end
    end

endmodule

// File: rtl/sys_row_driver.sv
// Producer-side sequencer for one systolic row. Loads one weight word into
// every PE with a single-cycle write pulse, streams vec_len activations with
// active framing, then idles the row for row_width cycles so it can flush.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : begin a job (sampled only in IDLE)
//   vec_len, sum_init   : job length and partial-sum seed, latched on start
//   w_data/w_valid/w_ready : weight word channel (PE0 in the low byte)
//   a_data/a_valid/a_ready : activation byte channel
//   row_active, row_data, row_w, row_sum, row_wren : registered row drives
//   busy                : not in IDLE
//   done                : one-cycle pulse at job end
module sys_row_driver
    import sys_row_driver_pkg::*;
#(
    parameter int row_width = 4,
    parameter int len_width = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [len_width-1:0]           vec_len,
    input  logic [sum_width*row_width-1:0] sum_init,
    input  logic [data_width*row_width-1:0] w_data,
    input  logic                           w_valid,
    output logic                           w_ready,
    input  logic [data_width-1:0]          a_data,
    input  logic                           a_valid,
    output logic                           a_ready,
    output logic                           row_active,
    output logic [data_width-1:0]          row_data,
    output logic [data_width*row_width-1:0] row_w,
    output logic [sum_width*row_width-1:0] row_sum,
    output logic [row_width-1:0]           row_wren,
    output logic                           busy,
    output logic                           done
);

    localparam int flush_width = $clog2(row_width + 1);

    state_t               state, state_nxt;
    logic [len_width-1:0] len_q;
    logic [len_width-1:0] cnt;
    logic                 w_fire, a_fire;
    logic                 flush_load, flush_dec, flush_zero;

    // Handshake readies and status come straight from registered state, so
    // they are glitch-free and never depend combinationally on the valids.
    assign w_ready = (state == LOAD);
    assign a_ready = (state == STREAM) && (cnt < len_q);
    assign busy    = (state != IDLE);
    assign done    = (state == FIN);

    assign w_fire  = w_valid && w_ready;
    assign a_fire  = a_valid && a_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            // NOTE: registers use non-blocking assignment so every flop samples
            // pre-edge values, independent of statement order.
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        state_nxt  = state;
        flush_load = 1'b0;
        flush_dec  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nxt = LOAD;
            end
            LOAD: begin
                if (w_fire) begin
                    if (len_q == '0) begin
                        state_nxt  = DRAIN;
                        flush_load = 1'b1;
                    end else begin
                        state_nxt  = STREAM;
                    end
                end
            end
            STREAM: begin
                // len_q > 0 here and cnt < len_q whenever a_fire, so the
                // increment cannot overflow.
                if (a_fire && ((cnt + len_width'(1)) == len_q)) begin
                    state_nxt  = DRAIN;
                    flush_load = 1'b1;
                end
            end
            DRAIN: begin
                flush_dec = 1'b1;
                if (flush_zero) state_nxt = FIN;
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // The counter holds remaining DRAIN cycles minus one, so the cycle in
    // which it reads zero is the last DRAIN cycle.
    sys_row_flush_ctr #(
        .width (flush_width)
    ) u_flush_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (flush_load),
        .load_val (flush_width'(row_width - 1)),
        .dec      (flush_dec),
        .zero     (flush_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: every datapath register is reset, including the wide
            // row_w/row_sum holds, so the row sees all-zero drives after reset.
            len_q      <= '0;
            cnt        <= '0;
            row_active <= 1'b0;
            row_data   <= '0;
            row_w      <= '0;
            row_sum    <= '0;
            row_wren   <= '0;
        end else begin
            // Pulses and the activation lane return to zero unless refreshed.
            row_wren   <= '0;
            row_active <= 1'b0;
            row_data   <= '0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        len_q   <= vec_len;
                        row_sum <= sum_init;
                        cnt     <= '0;
                    end
                end
                LOAD: begin
                    if (w_fire) begin
                        row_w    <= w_data;
                        row_wren <= '1;
                    end
                end
                STREAM: begin
                    if (a_fire) begin
                        row_active <= 1'b1;
                        row_data   <= a_data;
                        cnt        <= cnt + len_width'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
